ir_command_receiver: RTL and testbench

//  Bus peripheral that decodes demodulated IR car-command packets (start burst + 4 direction bits) from an IR receiver diode.

---
 rtl/ir_command_receiver.sv | 153 +++++++++++++++
 tb/tb_ir_command_receiver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_command_receiver.sv
// IR car-command receiver: decodes a start burst plus four direction bits (R,L,B,F) from a
// demodulated IR diode and exposes them to the CPU via a status register and an interrupt.
module ir_command_receiver #(
  parameter logic [7:0]  BASE_ADDR   = 8'hA0,
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned START_MIN   = 2000,
  parameter int unsigned BIT_MIN     = 300,
  parameter int unsigned BIT_ONE_MIN = 1000,
  parameter int unsigned GAP_MAX     = 1500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IR_IN,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [15:0] PRE_LAST_C    = 16'(TICK_DIV - 1);
  localparam logic [11:0] START_MIN_C   = 12'(START_MIN);
  localparam logic [11:0] BIT_MIN_C     = 12'(BIT_MIN);
  localparam logic [11:0] BIT_ONE_MIN_C = 12'(BIT_ONE_MIN);
  localparam logic [11:0] GAP_MAX_C     = 12'(GAP_MAX);
  localparam logic [7:0]  CLR_ADDR_C    = BASE_ADDR + 8'd1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_BIT, S_DONE} state_t;

  state_t      state_r;
  logic        ir_meta_r, ir_sync_r, ir_prev_r;
  logic [15:0] pre_r;
  logic [11:0] cnt_r;
  logic [1:0]  bit_idx_r;
  logic [3:0]  shift_r;
  logic [3:0]  cmd_r;
  logic        valid_r, overrun_r, raise_r;
  logic        rd_en_r;
  logic [7:0]  rd_data_r;

  logic tick_s, rise_s, fall_s, rd_s, clr_s;

  assign tick_s = (pre_r == PRE_LAST_C);
  assign rise_s = ir_sync_r & ~ir_prev_r;
  assign fall_s = ~ir_sync_r & ir_prev_r;
  assign rd_s   = (BUS_ADDR == BASE_ADDR) && !BUS_WE;
  assign clr_s  = (BUS_ADDR == CLR_ADDR_C) && BUS_WE;

  // Two-stage synchroniser for the asynchronous diode input, plus one delayed copy for edges
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_meta_r <= 1'b0;
      ir_sync_r <= 1'b0;
      ir_prev_r <= 1'b0;
    end else begin
      ir_meta_r <= IR_IN;
      ir_sync_r <= ir_meta_r;
      ir_prev_r <= ir_sync_r;
    end
  end

  // Free-running tick prescaler and saturating burst/gap width counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_r <= 16'd0;
      cnt_r <= 12'd0;
    end else begin
      if (tick_s) pre_r <= 16'd0;
      else        pre_r <= pre_r + 16'd1;
      if (rise_s || fall_s)                cnt_r <= 12'd0;
      else if (tick_s && cnt_r != 12'hFFF) cnt_r <= cnt_r + 12'd1;
      else                                 cnt_r <= cnt_r;
    end
  end

  // Packet decoder FSM with the status register and interrupt it owns
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= S_IDLE;
      bit_idx_r <= 2'd0;
      shift_r   <= 4'd0;
      cmd_r     <= 4'd0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      raise_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE:  if (rise_s) state_r <= S_START;
        S_START: begin
          if (fall_s) begin
            if (cnt_r >= START_MIN_C) begin
              state_r   <= S_GAP;
              bit_idx_r <= 2'd0;
              shift_r   <= 4'd0;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (rise_s)                 state_r <= S_BIT;
          else if (cnt_r > GAP_MAX_C) state_r <= S_IDLE;
        end
        S_BIT: begin
          if (fall_s) begin
            if (cnt_r < BIT_MIN_C) begin
              state_r <= S_IDLE;
            end else begin
              // first bit received (R) ends up in shift_r[3]
              shift_r <= {shift_r[2:0], (cnt_r >= BIT_ONE_MIN_C)};
              if (bit_idx_r == 2'd3) begin
                state_r <= S_DONE;
              end else begin
                bit_idx_r <= bit_idx_r + 2'd1;
                state_r   <= S_GAP;
              end
            end
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase

      // a completed packet beats a simultaneous clear, which still suppresses overrun
      if (state_r == S_DONE) begin
        cmd_r     <= shift_r;
        valid_r   <= 1'b1;
        overrun_r <= valid_r & ~clr_s;
      end else if (clr_s) begin
        valid_r   <= 1'b0;
        overrun_r <= 1'b0;
      end

      if (state_r == S_DONE)       raise_r <= 1'b1;
      else if (BUS_INTERRUPT_ACK) raise_r <= 1'b0;
    end
  end

  // Registered bus read path: status appears one cycle after the address
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_en_r   <= 1'b0;
      rd_data_r <= 8'd0;
    end else begin
      rd_en_r   <= rd_s;
      rd_data_r <= {valid_r, overrun_r, 2'b00, cmd_r};
    end
  end

  assign BUS_DATA            = rd_en_r ? rd_data_r : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_r;

endmodule

// File: tb/tb_ir_command_receiver.sv
// Bench for ir_command_receiver: directed packet scenarios then randomized packets, checked
// against a packet-level model of the status register and interrupt (thresholds scaled by 10).
module tb_ir_command_receiver;

  localparam int TD          = 2;
  localparam int START_MIN   = 200;
  localparam int BIT_MIN     = 30;
  localparam int BIT_ONE_MIN = 100;
  localparam int GAP_MAX     = 150;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir_in = 1'b0;
  logic [7:0] bus_addr = 8'h00;
  logic       bus_we = 1'b0;
  logic       bus_ack = 1'b0;
  wire  [7:0] bus_data;
  logic       raise;

  int total = 0;
  int bad = 0;

  // packet description in ticks: start width, gaps (after start, then between bits), bit widths
  int st;
  int gp [4];
  int bw [4];
  int kind, pos;

  logic       exp_valid = 1'b0;
  logic       exp_overrun = 1'b0;
  logic       exp_raise = 1'b0;
  logic [3:0] exp_cmd = 4'd0;
  logic [7:0] rd;

  ir_command_receiver #(
    .BASE_ADDR(8'hA0), .TICK_DIV(TD), .START_MIN(START_MIN),
    .BIT_MIN(BIT_MIN), .BIT_ONE_MIN(BIT_ONE_MIN), .GAP_MAX(GAP_MAX)
  ) dut (
    .CLK(clk), .RST(rst), .IR_IN(ir_in), .BUS_ADDR(bus_addr), .BUS_DATA(bus_data),
    .BUS_WE(bus_we), .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {exp_valid, exp_overrun, 2'b00, exp_cmd};
  endfunction

  task automatic read_status(output logic [7:0] d);
    bus_addr = 8'hA0;
    bus_we   = 1'b0;
    step(1);
    d        = bus_data;
    bus_addr = 8'h00;
  endtask

  task automatic write_clear();
    bus_addr = 8'hA1;
    bus_we   = 1'b1;
    step(1);
    bus_we   = 1'b0;
    bus_addr = 8'h00;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic do_ack();
    bus_ack = 1'b1;
    step(1);
    bus_ack = 1'b0;
    exp_raise = 1'b0;
  endtask

  task automatic set_pkt(input int s, input int g, input int b0, input int b1,
                         input int b2, input int b3);
    st = s;
    for (int i = 0; i < 4; i++) gp[i] = g;
    bw[0] = b0; bw[1] = b1; bw[2] = b2; bw[3] = b3;
  endtask

  // leaves IR_IN freshly low at a falling clock edge after the last data burst
  task automatic send_packet();
    ir_in = 1'b1; step(st * TD);
    ir_in = 1'b0; step(gp[0] * TD);
    for (int i = 0; i < 4; i++) begin
      ir_in = 1'b1; step(bw[i] * TD);
      ir_in = 1'b0;
      if (i < 3) step(gp[i + 1] * TD);
    end
  endtask

  task automatic model_packet(input logic clr_same);
    logic ok;
    ok = (st >= START_MIN);
    for (int i = 0; i < 4; i++) if (gp[i] > GAP_MAX || bw[i] < BIT_MIN) ok = 1'b0;
    if (ok) begin
      exp_overrun = exp_valid && !clr_same;
      exp_valid   = 1'b1;
      for (int i = 0; i < 4; i++) exp_cmd[3 - i] = (bw[i] >= BIT_ONE_MIN);
      exp_raise   = 1'b1;
    end
  endtask

  task automatic expect_state(input string tag, input logic er, input logic [7:0] es);
    check({tag, "_raise"}, {7'd0, raise}, {7'd0, er});
    read_status(rd);
    check({tag, "_status"}, rd, es);
  endtask

  task automatic run_packet();
    send_packet();
    step(20);
    model_packet(1'b0);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);
    expect_state("reset", 1'b0, 8'h00);

    set_pkt(220, 50, 120, 40, 40, 120);
    run_packet();
    expect_state("t1", 1'b1, 8'h89);
    do_ack();
    check("t1_ack", {7'd0, raise}, 8'h00);

    set_pkt(220, 50, 40, 120, 120, 40);
    run_packet();
    expect_state("t2", 1'b1, 8'hC6);
    write_clear();
    read_status(rd);
    check("t2_clear", rd, 8'h06);
    do_ack();

    set_pkt(150, 50, 120, 40, 40, 120);
    run_packet();
    expect_state("t3_short_start", 1'b0, 8'h06);

    set_pkt(220, 50, 40, 120, 120, 40);
    gp[2] = 160;
    run_packet();
    expect_state("t4_long_gap", 1'b0, 8'h06);
    set_pkt(220, 50, 40, 40, 120, 120);
    run_packet();
    expect_state("t4", 1'b1, 8'h83);
    do_ack();
    check("t4_ack", {7'd0, raise}, 8'h00);

    set_pkt(220, 50, 120, 10, 40, 120);
    run_packet();
    expect_state("t5_glitch", 1'b0, 8'h83);

    // ACK and a clear write land in the DONE cycle, three clocks after the last fall
    set_pkt(220, 50, 120, 40, 120, 40);
    send_packet();
    step(3);
    bus_ack  = 1'b1;
    bus_addr = 8'hA1;
    bus_we   = 1'b1;
    step(1);
    bus_ack  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = 8'h00;
    model_packet(1'b1);
    step(5);
    expect_state("t5_ack_done", 1'b1, 8'h8A);

    ir_in = 1'b1; step(220 * TD);
    ir_in = 1'b0; step(50 * TD);
    ir_in = 1'b1; step(120 * TD);
    ir_in = 1'b0; step(50 * TD);
    ir_in = 1'b1; step(20 * TD);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_valid = 1'b0; exp_overrun = 1'b0; exp_raise = 1'b0; exp_cmd = 4'd0;
    expect_state("t6_reset", 1'b0, 8'h00);
    step(30 * TD);
    ir_in = 1'b0;
    step(60 * TD);
    expect_state("t6_after_reset", 1'b0, 8'h00);
    set_pkt(220, 50, 120, 120, 40, 40);
    run_packet();
    expect_state("t6", 1'b1, 8'h8C);
    do_ack();

    for (int n = 0; n < 6; n++) begin
      kind = $urandom_range(0, 3);
      pos  = $urandom_range(0, 3);
      st   = $urandom_range(210, 260);
      for (int i = 0; i < 4; i++) begin
        gp[i] = $urandom_range(20, 130);
        bw[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(110, 140) : $urandom_range(35, 90);
      end
      case (kind)
        1: st      = $urandom_range(100, 180);
        2: gp[pos] = $urandom_range(165, 220);
        3: bw[pos] = $urandom_range(5, 20);
        default: ;
      endcase
      run_packet();
      expect_state($sformatf("rnd%0d_k%0d", n, kind), exp_raise, exp_status());
      if ($urandom_range(0, 1) == 1) write_clear();
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        check($sformatf("rnd%0d_ack", n), {7'd0, raise}, 8'h00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
